// File: rtl/wb_loader.sv
// -----------------------------------------------------------------------------
// wb_loader
//
// Write-side loader for the weight/bias bank memories. A host streams 32-bit
// words over a valid/ready handshake. The loader fills NBANKS banks in order:
// bank 0 addresses 0..len-1, then bank 1, and so on. It flags completion so
// the inference sequencer can start reading.
//
// Optional feature: define WBL_CHECKSUM_EN to add a running modulo-2^32 sum
// of the accepted words, plus a compare against exp_sum. When the macro is
// undefined, exp_sum does not exist and checksum/chk_err are tied to 0.
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous, active-high reset
//   start         one-cycle pulse; begins a session from IDLE or DONE
//   abort         return to IDLE on the next edge (has priority over a transfer)
//   len [AW]      words per bank, latched on start (0 or > DEPTH means DEPTH)
//   in_valid      host word valid
//   in_data [32]  host word
//   in_ready      high in every LOAD cycle
//   wr_en         bank write strobe, one cycle per accepted word (registered)
//   wr_bank [BW]  target bank index
//   wr_addr [AW]  target address within the bank
//   wr_data [32]  write data
//   busy          state is LOAD
//   done          state is DONE; held until start, abort or reset
//   words_loaded  accepted words in the current session
//   checksum      running sum of accepted words (WBL_CHECKSUM_EN only, else 0)
//   chk_err       checksum != exp_sum, from the second DONE cycle (else 0)
//   exp_sum       expected sum, sampled in the first DONE cycle (macro only)
// -----------------------------------------------------------------------------
module wb_loader #(
   parameter int NBANKS = 42,
   parameter int DEPTH  = 1025,
   parameter int AW     = 11,
   parameter int BW     = 6
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          abort,
   input  logic [AW-1:0] len,
   input  logic          in_valid,
   input  logic [31:0]   in_data,
`ifdef WBL_CHECKSUM_EN
   input  logic [31:0]   exp_sum,
`endif
   output logic          in_ready,
   output logic          wr_en,
   output logic [BW-1:0] wr_bank,
   output logic [AW-1:0] wr_addr,
   output logic [31:0]   wr_data,
   output logic          busy,
   output logic          done,
   output logic [31:0]   words_loaded,
   output logic [31:0]   checksum,
   output logic          chk_err
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [AW-1:0] DEPTH_A   = AW'(DEPTH);
   localparam logic [BW-1:0] LAST_BANK = BW'(NBANKS - 1);

   logic [1:0]    state;
   logic [BW-1:0] bank;
   logic [AW-1:0] addr;
   logic [AW-1:0] len_q;
   logic [AW-1:0] len_eff;
   logic          addr_last;
   logic          bank_last;
   logic          begin_session;

   // NOTE: every variable gets a value on every path through this block, so
   // no latch is inferred.
   always_comb begin
      len_eff = len;
      if (len == '0 || len > DEPTH_A)
         len_eff = DEPTH_A;
   end

   assign in_ready      = (state == S_LOAD);
   assign busy          = (state == S_LOAD);
   assign done          = (state == S_DONE);
   assign addr_last     = (addr == len_q - AW'(1));
   assign bank_last     = (bank == LAST_BANK);
   assign begin_session = start && (state != S_LOAD);

   // The main FSM, the bank/address counters and the registered write port.
   // NOTE: sequential state uses non-blocking assignments, so every register
   // in this block samples the values from before the edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_IDLE;
         bank         <= '0;
         addr         <= '0;
         len_q        <= '0;
         wr_en        <= 1'b0;
         wr_bank      <= '0;
         wr_addr      <= '0;
         wr_data      <= '0;
         words_loaded <= '0;
      end else begin
         wr_en <= 1'b0;
         if (abort) begin
            // Counters are deliberately left alone; the next start clears them.
            state <= S_IDLE;
         end else if (begin_session) begin
            state        <= S_LOAD;
            bank         <= '0;
            addr         <= '0;
            len_q        <= len_eff;
            words_loaded <= '0;
         end else if (state == S_LOAD && in_valid) begin
            wr_en        <= 1'b1;
            wr_bank      <= bank;
            wr_addr      <= addr;
            wr_data      <= in_data;
            words_loaded <= words_loaded + 32'd1;
            if (addr_last) begin
               addr <= '0;
               // The bank counter stops at the last bank, so it can never
               // reach NBANKS.
               if (bank_last)
                  state <= S_DONE;
               else
                  bank <= bank + BW'(1);
            end else begin
               addr <= addr + AW'(1);
            end
         end
      end
   end

`ifdef WBL_CHECKSUM_EN
   logic last_word;
   logic first_done;

   assign last_word = addr_last && bank_last;

   // first_done is high only in the first DONE cycle. That cycle's edge
   // latches the comparison, so chk_err becomes valid from the second DONE
   // cycle and then holds.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         checksum   <= '0;
         chk_err    <= 1'b0;
         first_done <= 1'b0;
      end else if (abort) begin
         chk_err    <= 1'b0;
         first_done <= 1'b0;
      end else if (begin_session) begin
         checksum   <= '0;
         chk_err    <= 1'b0;
         first_done <= 1'b0;
      end else if (state == S_LOAD && in_valid) begin
         checksum   <= checksum + in_data;
         first_done <= last_word;
      end else if (first_done) begin
         chk_err    <= (checksum != exp_sum);
         first_done <= 1'b0;
      end
   end
`else
   assign checksum = '0;
   assign chk_err  = 1'b0;
`endif

endmodule

// File: tb/tb_wb_loader.sv
// -----------------------------------------------------------------------------
// tb_wb_loader
//
// Randomized scoreboard bench for wb_loader. The driver keeps a session-level
// reference model: word k of a session goes to bank k/len_eff, address
// k%len_eff. For every word the model accepts, the driver queues the expected
// write together with the cycle in which the write must appear. A separate
// negedge monitor pops that queue whenever wr_en is high. It also checks that
// the write port holds its values between strobes. Build with
// +define+WBL_CHECKSUM_EN to also exercise the checksum feature.
// -----------------------------------------------------------------------------
module tb_wb_loader;

   localparam int NB    = 42;
   localparam int DEPTH = 1025;
   localparam int AW    = 11;
   localparam int BW    = 6;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [AW-1:0] len = '0;
   logic          in_valid = 1'b0;
   logic [31:0]   in_data = '0;
   logic          in_ready;
   logic          wr_en;
   logic [BW-1:0] wr_bank;
   logic [AW-1:0] wr_addr;
   logic [31:0]   wr_data;
   logic          busy;
   logic          done;
   logic [31:0]   words_loaded;
   logic [31:0]   checksum;
   logic          chk_err;
`ifdef WBL_CHECKSUM_EN
   logic [31:0]   exp_sum = '0;
`endif

   wb_loader #(.NBANKS(NB), .DEPTH(DEPTH), .AW(AW), .BW(BW)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .len(len),
      .in_valid(in_valid), .in_data(in_data),
`ifdef WBL_CHECKSUM_EN
      .exp_sum(exp_sum),
`endif
      .in_ready(in_ready), .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr),
      .wr_data(wr_data), .busy(busy), .done(done), .words_loaded(words_loaded),
      .checksum(checksum), .chk_err(chk_err)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc++;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard and checking ----------------
   typedef struct {
      int unsigned cyc;
      int          bank;
      int          addr;
      logic [31:0] data;
   } wr_t;

   wr_t sb[$];

   int vectors     = 0;
   int miscompares = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Values the write port must hold while wr_en is low.
   logic [BW-1:0] hold_bank = '0;
   logic [AW-1:0] hold_addr = '0;
   logic [31:0]   hold_data = '0;
   int            wr_pulses = 0;

   always @(negedge clk) begin
      if (!rst) begin
         if (wr_en) begin
            wr_pulses++;
            if (sb.size() == 0) begin
               check("wr_en_spurious", 32'(wr_en), 32'd0);
            end else begin
               wr_t e;
               e = sb.pop_front();
               check("wr_cycle", cyc, e.cyc);
               check("wr_bank", 32'(wr_bank), 32'(e.bank));
               check("wr_addr", 32'(wr_addr), 32'(e.addr));
               check("wr_data", wr_data, e.data);
               hold_bank = BW'(e.bank);
               hold_addr = AW'(e.addr);
               hold_data = e.data;
            end
         end else begin
            if (sb.size() != 0 && sb[0].cyc == cyc) begin
               check("wr_en_missing", 32'(wr_en), 32'd1);
               void'(sb.pop_front());
            end
            check("hold_bank", 32'(wr_bank), 32'(hold_bank));
            check("hold_addr", 32'(wr_addr), 32'(hold_addr));
            check("hold_data", wr_data, hold_data);
         end
      end
   end

   // ---------------- reference model ----------------
   typedef enum {M_IDLE, M_LOAD, M_DONE} mstate_t;
   mstate_t     m_state = M_IDLE;
   int          m_cnt   = 0;
   int          m_len   = 0;
   logic [31:0] m_sum   = '0;

   // One clock cycle. Called at posedge+1. It checks the status outputs
   // against the model, applies the inputs, advances the model and waits for
   // the next edge.
   task automatic drive(input bit v, input logic [31:0] d,
                        input bit st = 1'b0, input bit ab = 1'b0,
                        input logic [AW-1:0] l = '0);
      wr_t e;
      check("in_ready", 32'(in_ready), 32'(m_state == M_LOAD));
      check("busy", 32'(busy), 32'(m_state == M_LOAD));
      check("done", 32'(done), 32'(m_state == M_DONE));
      check("words_loaded", words_loaded, 32'(m_cnt));
`ifdef WBL_CHECKSUM_EN
      check("checksum", checksum, m_sum);
`else
      check("checksum_off", checksum, 32'd0);
      check("chk_err_off", 32'(chk_err), 32'd0);
`endif
      in_valid = v;
      in_data  = d;
      start    = st;
      abort    = ab;
      len      = l;
      if (ab) begin
         m_state = M_IDLE;
      end else if (st && m_state != M_LOAD) begin
         m_len   = (int'(l) == 0 || int'(l) > DEPTH) ? DEPTH : int'(l);
         m_cnt   = 0;
         m_sum   = '0;
         m_state = M_LOAD;
      end else if (m_state == M_LOAD && v) begin
         e.cyc  = cyc + 1;
         e.bank = m_cnt / m_len;
         e.addr = m_cnt % m_len;
         e.data = d;
         sb.push_back(e);
         m_sum = m_sum + d;
         m_cnt++;
         if (m_cnt == NB * m_len)
            m_state = M_DONE;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      abort = 1'b0;
   endtask

   task automatic do_reset();
      #1 rst = 1'b1;
      #1;
      sb.delete();
      m_state   = M_IDLE;
      m_cnt     = 0;
      m_sum     = '0;
      hold_bank = '0;
      hold_addr = '0;
      hold_data = '0;
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_wr_en", 32'(wr_en), 32'd0);
      check("rst_wr_bank", 32'(wr_bank), 32'd0);
      check("rst_wr_addr", 32'(wr_addr), 32'd0);
      check("rst_wr_data", wr_data, 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_words_loaded", words_loaded, 32'd0);
      check("rst_checksum", checksum, 32'd0);
      check("rst_chk_err", 32'(chk_err), 32'd0);
      @(negedge clk);
      #2 rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   // Run the current session to DONE with in_valid held high and a bounded
   // cycle budget.
   task automatic run_full(input int budget);
      int n = 0;
      while (m_state == M_LOAD && n < budget) begin
         drive(1'b1, 32'(m_cnt));
         n++;
      end
      check("session_finished", 32'(m_state == M_DONE), 32'd1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int nvalid;

      do_reset();

      // Full session with len=785 and no gaps: 42*785 writes.
      wr_pulses = 0;
      drive(1'b0, '0, 1'b1, 1'b0, AW'(785));
      run_full(40000);
      drive(1'b1, 32'hdead_beef);          // offered in DONE, must be refused
      drive(1'b0, '0);
      check("total_words", words_loaded, 32'd32970);
      check("total_pulses", 32'(wr_pulses), 32'd32970);
      check("final_bank", 32'(wr_bank), 32'd41);
      check("final_addr", 32'(wr_addr), 32'd784);
      check("sb_empty_785", 32'(sb.size()), 32'd0);

      // len=0 and len=1025 both mean 1025: run past the first two bank wraps.
      for (int k = 0; k < 2; k++) begin
         drive(1'b0, '0, 1'b1, 1'b0, (k == 0) ? AW'(0) : AW'(1025));
         for (int i = 0; i < 2 * DEPTH + 5; i++)
            drive(1'b1, $urandom);
         drive(1'b1, $urandom, 1'b0, 1'b1);  // abort beats this transfer
         drive(1'b0, '0);
         check("wrap_bank", 32'(wr_bank), 32'd2);
         check("wrap_addr", 32'(wr_addr), 32'd4);
      end

      // len=4 with random in_valid gaps, run to completion.
      drive(1'b0, '0, 1'b1, 1'b0, AW'(4));
      for (int n = 0; n < 2000 && m_state == M_LOAD; n++)
         drive(1'($urandom_range(0, 1)), $urandom);
      check("gap_finished", 32'(m_state == M_DONE), 32'd1);
      drive(1'b0, '0);
      check("gap_words", words_loaded, 32'd168);

      // Abort together with the 10th valid word.
      drive(1'b0, '0, 1'b1, 1'b0, AW'(4));
      nvalid = 0;
      for (int n = 0; n < 200 && nvalid < 10; n++) begin
         bit v;
         v = 1'($urandom_range(0, 1));
         if (v) nvalid++;
         drive(v, $urandom, 1'b0, (nvalid == 10));
      end
      drive(1'b1, $urandom);               // IDLE: must not be accepted
      check("abort_words", words_loaded, 32'd9);
      drive(1'b0, '0, 1'b1, 1'b0, AW'(4)); // restart from bank 0 addr 0
      for (int i = 0; i < 3; i++)
         drive(1'b1, $urandom);
      drive(1'b0, '0, 1'b0, 1'b1);

      // Asynchronous reset after 50 words, with in_valid kept high.
      drive(1'b0, '0, 1'b1, 1'b0, AW'(785));
      for (int i = 0; i < 50; i++)
         drive(1'b1, $urandom);
      do_reset();
      for (int i = 0; i < 3; i++)
         drive(1'b1, $urandom);
      drive(1'b0, '0, 1'b1, 1'b0, AW'(785));
      for (int i = 0; i < 5; i++)
         drive(1'b1, $urandom);
      drive(1'b0, '0, 1'b0, 1'b1);
      drive(1'b0, '0);

`ifdef WBL_CHECKSUM_EN
      // 84 words of 1: a matching expected sum, then a mismatching one.
      for (int k = 0; k < 2; k++) begin
         exp_sum = (k == 0) ? 32'd84 : 32'd83;
         drive(1'b0, '0, 1'b1, 1'b0, AW'(2));
         for (int n = 0; n < 200 && m_state == M_LOAD; n++)
            drive(1'b1, 32'd1);
         check("chk_first_done", 32'(chk_err), 32'd0);
         drive(1'b0, '0);
         check("chk_sum", checksum, 32'd84);
         check("chk_err", 32'(chk_err), (k == 0) ? 32'd0 : 32'd1);
         drive(1'b0, '0);
      end
      drive(1'b0, '0, 1'b0, 1'b1);
      check("chk_err_abort", 32'(chk_err), 32'd0);
`endif

      drive(1'b0, '0);
      check("sb_empty_end", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
